uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_controller transmit path between NUM_REQ
// producers; each frame is {tag, payload} issued as a single tx_vld strobe.

module uart_tx_slot #(
  parameter int PAY_BITS = 136
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld,
  input  logic [PAY_BITS-1:0] data,
  input  logic                clr,
  output logic                rdy,
  output logic                pending,
  output logic [PAY_BITS-1:0] payload
);
  logic take;
  assign take = vld & rdy;

  // rdy trails pending by one cycle so it returns only the cycle after done
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      rdy     <= 1'b1;
      payload <= '0;
    end else begin
      if (take) begin
        pending <= 1'b1;
        payload <= data;
      end else if (clr) begin
        pending <= 1'b0;
      end
      rdy <= ~take & ~pending;
    end
  end
endmodule

module uart_tx_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int          FRAME_BYTES = 18,
  parameter logic [3:0]  TAG_HI      = 4'hA,
  localparam int         PAY_BITS    = (FRAME_BYTES-1)*8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*PAY_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [FRAME_BYTES*8-1:0]      utx_data,
  output logic                          utx_vld,
  input  logic                          utx_rdy,
  output logic                          busy,
  output logic [3:0]                    grant_id
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACC  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]                         sstate;
  logic [1:0]                         acc_cnt;
  logic [NUM_REQ-1:0]                 pending;
  logic [NUM_REQ-1:0]                 cur_oh;
  logic [NUM_REQ-1:0]                 slot_clr;
  logic [NUM_REQ-1:0]                 win_oh;
  logic [NUM_REQ-1:0][PAY_BITS-1:0]   slot_pay;
  logic                               win_found;
  logic [3:0]                         win_id;
  logic [PAY_BITS-1:0]                win_pay;
  logic                               done_now;

  assign done_now = (sstate == S_WAIT_DONE) & utx_rdy;
  assign slot_clr = {NUM_REQ{done_now}} & cur_oh;
  assign utx_vld  = (sstate == S_ISSUE);
  assign busy     = (sstate != S_IDLE);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      uart_tx_slot #(.PAY_BITS(PAY_BITS)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .vld     (req_vld[gi]),
        .data    (req_data[gi*PAY_BITS +: PAY_BITS]),
        .clr     (slot_clr[gi]),
        .rdy     (req_rdy[gi]),
        .pending (pending[gi]),
        .payload (slot_pay[gi])
      );
    end
  endgenerate

  // First pass looks above the last grant, second pass wraps to the lowest index
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    win_pay   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && pending[k] && (k > int'(grant_id))) begin
        win_found = 1'b1;
        win_id    = 4'(k);
        win_oh[k] = 1'b1;
        win_pay   = slot_pay[k];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && pending[k]) begin
        win_found = 1'b1;
        win_id    = 4'(k);
        win_oh[k] = 1'b1;
        win_pay   = slot_pay[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sstate   <= S_IDLE;
      acc_cnt  <= '0;
      cur_oh   <= '0;
      grant_id <= 4'(NUM_REQ-1);
      utx_data <= '0;
      req_done <= '0;
    end else begin
      req_done <= '0;
      case (sstate)
        S_IDLE: begin
          if (win_found && utx_rdy) begin
            grant_id <= win_id;
            cur_oh   <= win_oh;
            utx_data <= {TAG_HI, win_id, win_pay};
            sstate   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          acc_cnt <= '0;
          sstate  <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          // controller never dropped tx_rdy: assume the strobe was missed
          if (!utx_rdy)              sstate  <= S_WAIT_DONE;
          else if (acc_cnt == 2'd2)  sstate  <= S_ISSUE;
          else                       acc_cnt <= acc_cnt + 2'd1;
        end
        S_WAIT_DONE: begin
          if (utx_rdy) begin
            req_done <= cur_oh;
            sstate   <= S_IDLE;
          end
        end
        default: begin
          sstate   <= S_IDLE;
          acc_cnt  <= '0;
          cur_oh   <= '0;
          grant_id <= 4'(NUM_REQ-1);
          utx_data <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: transaction-level model checked every cycle,
// a uart_controller stub on utx_rdy, and literal checks on grant order and latency.

module tb_uart_tx_scheduler;
  localparam int NR   = 4;
  localparam int FB   = 18;
  localparam int PB   = (FB-1)*8;
  localparam int FW   = FB*8;
  localparam int LINE = 10;

  logic              clk, rst;
  logic [NR-1:0]     req_vld, req_rdy, req_done;
  logic [NR*PB-1:0]  req_data;
  logic [FW-1:0]     utx_data;
  logic              utx_vld, utx_rdy, busy;
  logic [3:0]        grant_id;

  uart_tx_scheduler #(.NUM_REQ(NR), .FRAME_BYTES(FB), .TAG_HI(4'hA)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .req_done(req_done), .utx_data(utx_data), .utx_vld(utx_vld), .utx_rdy(utx_rdy),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_n = 0, err_n = 0, cyc_n = 0;
  bit chk_on = 0;

  // model state
  bit [NR-1:0]   m_pend, m_rdy, m_done;
  logic [PB-1:0] m_pay [NR];
  int            m_last, m_w, m_hi, mc;
  bit            m_fly, m_pulse, m_low, m_pick;
  logic [FW-1:0] m_frame;

  // controller stub and event log
  bit            line_busy, post_done;
  int            line_cnt, ign, rise_cyc, done_cnt, off_c;
  logic [FW-1:0] line_frame;
  logic [7:0]    tags[$];
  logic [FW-1:0] frames[$];
  int            vld_cyc[$], done_cyc[$];
  int            acc_cyc [NR];
  bit [NR-1:0]   sat, rdy_at_done, rdy_after_done;

  logic [PB-1:0] p0, p1, p2, p3;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tg(input int i);
    return (i < tags.size()) ? tags[i] : 8'h00;
  endfunction
  function automatic logic [FW-1:0] fr(input int i);
    return (i < frames.size()) ? frames[i] : '0;
  endfunction
  function automatic int vc(input int i);
    return (i < vld_cyc.size()) ? vld_cyc[i] : -1000;
  endfunction
  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1000;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_rdy = '1; m_done = '0; m_last = NR-1; m_w = 0;
    m_fly = 0; m_pulse = 0; m_low = 0; m_hi = 0; m_frame = '0;
  endtask

  // One frame in flight: pulse, watch for tx_rdy to drop (re-pulse after 3 high
  // cycles), then finish when tx_rdy returns.
  task automatic model_step();
    bit [NR-1:0] acc, nd;
    nd  = '0;
    acc = req_vld & m_rdy;
    if (!m_fly) begin
      if (utx_rdy && m_pend != '0) begin
        m_pick = 0;
        for (int k = 1; k <= NR; k++) begin
          mc = (m_last + k) % NR;
          if (!m_pick && m_pend[mc]) begin m_pick = 1; m_w = mc; end
        end
        m_fly = 1; m_pulse = 1; m_last = m_w;
        m_frame = {4'hA, 4'(m_w), m_pay[m_w]};
      end
    end else if (m_pulse) begin
      m_pulse = 0; m_hi = 0; m_low = 0;
    end else if (!m_low) begin
      if (!utx_rdy) m_low = 1;
      else begin
        m_hi++;
        if (m_hi == 3) m_pulse = 1;
      end
    end else if (utx_rdy) begin
      nd[m_w] = 1'b1; m_fly = 0; m_pend[m_w] = 1'b0;
    end
    for (int i = 0; i < NR; i++)
      if (acc[i]) begin m_pend[i] = 1'b1; m_pay[i] = req_data[i*PB +: PB]; end
    for (int i = 0; i < NR; i++)
      m_rdy[i] = acc[i] ? 1'b0 : (m_done[i] ? 1'b1 : m_rdy[i]);
    m_done = nd;
  endtask

  task automatic cyc();
    bit [NR-1:0] took;
    @(negedge clk);
    if (chk_on) begin
      chk("req_rdy",  FW'(req_rdy),  FW'(m_rdy));
      chk("req_done", FW'(req_done), FW'(m_done));
      chk("utx_vld",  FW'(utx_vld),  FW'(m_pulse));
      chk("busy",     FW'(busy),     FW'(m_fly));
      chk("grant_id", FW'(grant_id), FW'(m_last));
      chk("utx_data", utx_data,      m_frame);
    end
    if (post_done) begin rdy_after_done = req_rdy; post_done = 0; end
    if (utx_vld) begin
      tags.push_back(utx_data[FW-1 -: 8]); frames.push_back(utx_data); vld_cyc.push_back(cyc_n);
    end
    if (req_done != '0) begin
      done_cnt++; done_cyc.push_back(cyc_n); rdy_at_done = req_rdy; post_done = 1;
    end
    if (rst) begin
      utx_rdy = 1'b1; line_busy = 0;
    end else if (line_busy) begin
      if (line_cnt == 0) begin utx_rdy = 1'b1; line_busy = 0; rise_cyc = cyc_n; end
      else line_cnt--;
    end else if (utx_vld) begin
      if (ign > 0) ign--;
      else begin line_busy = 1; line_cnt = LINE; utx_rdy = 1'b0; line_frame = utx_data; end
    end
    took = rst ? '0 : (req_vld & req_rdy);
    for (int i = 0; i < NR; i++) if (took[i]) acc_cyc[i] = cyc_n;
    @(posedge clk);
    cyc_n++;
    if (rst) begin model_reset(); chk_on = 1; end
    else model_step();
    #1;
    for (int i = 0; i < NR; i++)
      if (took[i]) begin
        if (sat[i]) req_data[i*PB +: PB] = req_data[i*PB +: PB] + PB'(1);
        else        req_vld[i] = 1'b0;
      end
  endtask

  task automatic offer(input int i, input logic [PB-1:0] d);
    req_vld[i] = 1'b1;
    req_data[i*PB +: PB] = d;
  endtask

  task automatic wait_dones(input int n, input string nm);
    int b = 0;
    while (done_cnt < n && b < 400) begin cyc(); b++; end
    chk(nm, FW'(done_cnt >= n), FW'(1));
  endtask

  task automatic wait_wd();
    int b = 0;
    while (!(busy && !utx_rdy) && b < 100) begin cyc(); b++; end
    chk("wait_in_flight", FW'(busy && !utx_rdy), FW'(1));
  endtask

  task automatic drain();
    int b = 0;
    while (!(req_rdy == '1 && !busy) && b < 400) begin cyc(); b++; end
    chk("drain", FW'(req_rdy == '1 && !busy), FW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; sat = '0; ign = 0;
    cyc(); cyc();
    rst = 1'b0;
    tags.delete(); frames.delete(); vld_cyc.delete(); done_cyc.delete();
    done_cnt = 0;
    for (int i = 0; i < NR; i++) acc_cyc[i] = -1;
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_data = '0; sat = '0; ign = 0; utx_rdy = 1'b1;
    line_busy = 0; line_cnt = 0; rise_cyc = -1; done_cnt = 0; post_done = 0;
    rdy_at_done = '1; rdy_after_done = '0;
    p0 = 136'h0102030405060708090a0b0c0d0e0f1011;
    p1 = {17{8'h11}}; p2 = {17{8'h5c}}; p3 = {17{8'h3e}};
    model_reset();
    do_reset();

    chk("rst_req_rdy",  FW'(req_rdy),  FW'(4'hF));
    chk("rst_req_done", FW'(req_done), FW'(0));
    chk("rst_utx_vld",  FW'(utx_vld),  FW'(0));
    chk("rst_utx_data", utx_data,      FW'(0));
    chk("rst_busy",     FW'(busy),     FW'(0));
    chk("rst_grant_id", FW'(grant_id), FW'(3));

    // single request from producer 0
    offer(0, p0);
    wait_dones(1, "t1_done_timeout");
    cyc(); cyc();
    chk("t1_pulses",       FW'(vld_cyc.size()),     FW'(1));
    chk("t1_frame",        fr(0),                   {8'hA0, p0});
    chk("t1_line_frame",   line_frame,              {8'hA0, p0});
    chk("t1_line_byte0",   FW'(line_frame[FW-1 -: 8]), FW'(8'hA0));
    chk("t1_acc_to_vld",   FW'(vc(0) - acc_cyc[0]), FW'(2));
    chk("t1_rise_to_done", FW'(dc(0) - rise_cyc),   FW'(1));
    chk("t1_rdy_at_done",  FW'(rdy_at_done[0]),     FW'(0));
    chk("t1_rdy_after",    FW'(rdy_after_done[0]),  FW'(1));

    // round-robin from reset, then re-arm 3 and 1
    do_reset();
    offer(0, p0); offer(1, p1); offer(2, p2); offer(3, p3);
    wait_dones(4, "t2_done_timeout");
    chk("t2_tag0", FW'(tg(0)), FW'(8'hA0));
    chk("t2_tag1", FW'(tg(1)), FW'(8'hA1));
    chk("t2_tag2", FW'(tg(2)), FW'(8'hA2));
    chk("t2_tag3", FW'(tg(3)), FW'(8'hA3));
    offer(3, p3); offer(1, p1);
    wait_dones(6, "t2_rearm_timeout");
    chk("t2_tag4", FW'(tg(4)), FW'(8'hA1));
    chk("t2_tag5", FW'(tg(5)), FW'(8'hA3));
    chk("t2_frame5", fr(5), {8'hA3, p3});
    cyc();
    chk("t2_grant_id", FW'(grant_id), FW'(3));

    // saturation: producers 0 and 2 always valid
    do_reset();
    sat = 4'b0101;
    offer(0, p0); offer(2, p2);
    wait_dones(6, "t3_done_timeout");
    sat = '0;
    drain();
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_tag%0d", k), FW'(tg(k)), FW'((k % 2 == 1) ? 8'hA2 : 8'hA0));

    // missed strobe: stub ignores the first pulse
    do_reset();
    ign = 1;
    offer(1, p1);
    wait_dones(1, "t4_done_timeout");
    chk("t4_pulses", FW'(vld_cyc.size()),  FW'(2));
    chk("t4_frame0", fr(0),                {8'hA1, p1});
    chk("t4_frame1", fr(1),                {8'hA1, p1});
    chk("t4_gap",    FW'(vc(1) - vc(0)),   FW'(4));

    // accept into slot 3 while frame 1 waits for completion
    do_reset();
    offer(1, p1);
    wait_wd();
    cyc();
    off_c = cyc_n;
    offer(3, p3);
    cyc();
    chk("t5_acc_immediate", FW'(acc_cyc[3]), FW'(off_c));
    wait_dones(2, "t5_done_timeout");
    chk("t5_tag0", FW'(tg(0)), FW'(8'hA1));
    chk("t5_tag1", FW'(tg(1)), FW'(8'hA3));
    chk("t5_done_to_issue", FW'(vc(1) - dc(0)), FW'(1));

    // reset while a frame waits for completion, with another slot pending
    do_reset();
    offer(2, p2);
    wait_wd();
    cyc();
    offer(0, p0);
    cyc(); cyc();
    rst = 1'b1; req_vld = '0;
    cyc();
    rst = 1'b0;
    chk("t6_req_rdy",  FW'(req_rdy),  FW'(4'hF));
    chk("t6_req_done", FW'(req_done), FW'(0));
    chk("t6_utx_vld",  FW'(utx_vld),  FW'(0));
    chk("t6_utx_data", utx_data,      FW'(0));
    chk("t6_busy",     FW'(busy),     FW'(0));
    chk("t6_grant_id", FW'(grant_id), FW'(3));
    repeat (30) cyc();
    chk("t6_no_done",  FW'(done_cnt), FW'(0));
    chk("t6_idle",     FW'(busy),     FW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
